// File: rtl/pe_int_pipe.sv
// Two-stage pipelined integer PE: add/sub/mul/mac/clr/min/max with overflow flag,
// valid/ready on both sides and a persistent accumulator updated in S2.
module pe_int_pipe #(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic [DATA_W-1:0] acc_value
);
  localparam int MSB = DATA_W - 1;
  // Flipping the MSB turns a two's-complement compare into an unsigned one.
  localparam logic [DATA_W-1:0] FLIP = SIGNED ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_MAC, OP_CLR, OP_MIN, OP_MAX, OP_ADDX
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } beat_t;

  logic              s1_valid_q, s1_valid_d;
  beat_t             s1_q, s1_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  logic                s1_ld, s2_ld;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  logic                prod_ovf, lt, res_ovf;
  logic [DATA_W:0]     add_r, sub_r, mac_r;
  logic [DATA_W-1:0]   res, acc_n;

  // Returns {overflow, result}; overflow is signed overflow or carry/borrow out.
  function automatic logic [DATA_W:0] addsub(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                             input logic sub);
    logic [DATA_W:0] r;
    logic            sov;
    r   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    sov = ((x[MSB] ^ y[MSB]) == sub) && (r[MSB] != x[MSB]);
    return {(SIGNED ? sov : r[DATA_W]), r[MSB:0]};
  endfunction

  always_comb begin
    s2_ld = !out_valid_q || out_ready;
    s1_ld = !s1_valid_q || s2_ld;

    ext_a = {{DATA_W{SIGNED & s1_q.a[MSB]}}, s1_q.a};
    ext_b = {{DATA_W{SIGNED & s1_q.b[MSB]}}, s1_q.b};
    prod  = ext_a * ext_b;
    if (SIGNED) prod_ovf = ~((&prod[2*DATA_W-1:MSB]) | ~(|prod[2*DATA_W-1:MSB]));
    else        prod_ovf = |prod[2*DATA_W-1:DATA_W];

    add_r = addsub(s1_q.a, s1_q.b, 1'b0);
    sub_r = addsub(s1_q.a, s1_q.b, 1'b1);
    mac_r = addsub(acc_q, prod[MSB:0], 1'b0);
    lt    = (s1_q.a ^ FLIP) < (s1_q.b ^ FLIP);

    res     = add_r[MSB:0];
    res_ovf = add_r[DATA_W];
    acc_n   = acc_q;
    case (s1_q.op)
      OP_SUB: begin res = sub_r[MSB:0]; res_ovf = sub_r[DATA_W]; end
      OP_MUL: begin res = prod[MSB:0]; res_ovf = prod_ovf; end
      OP_MAC: begin
        res     = mac_r[MSB:0];
        res_ovf = mac_r[DATA_W] | prod_ovf;
        acc_n   = mac_r[MSB:0];
      end
      OP_CLR: begin res = acc_q; res_ovf = 1'b0; acc_n = '0; end
      OP_MIN: begin res = lt ? s1_q.a : s1_q.b; res_ovf = 1'b0; end
      OP_MAX: begin res = lt ? s1_q.b : s1_q.a; res_ovf = 1'b0; end
      default: ;
    endcase

    s1_valid_d = s1_ld ? in_valid : s1_valid_q;
    s1_d       = s1_q;
    if (s1_ld && in_valid) s1_d = '{op: op_e'(in_op), a: in_a, b: in_b};

    out_valid_d = s2_ld ? s1_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    // acc only moves when its beat enters S2, so MAC/CLR effects stay in beat order.
    if (s2_ld && s1_valid_q) begin
      out_data_d = res;
      out_ovf_d  = res_ovf;
      acc_d      = acc_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  always_ff @(posedge clk) s1_q <= s1_d;

  assign in_ready  = s1_ld;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign acc_value = acc_q;
endmodule

// File: tb/tb_pe_int_pipe.sv
// Directed bench for pe_int_pipe: a signed and an unsigned 32-bit instance share stimulus.
module tb_pe_int_pipe;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         in_ready, out_valid, out_ovf;
  logic [W-1:0] out_data, acc_value;
  logic         u_in_ready, u_out_valid, u_out_ovf;
  logic [W-1:0] u_out_data, u_acc_value;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  pe_int_pipe #(.DATA_W(W), .SIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .acc_value(acc_value));

  pe_int_pipe #(.DATA_W(W), .SIGNED(1'b0)) u_dutu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_ovf(u_out_ovf), .acc_value(u_acc_value));

  // Called at a negedge with the pipe able to accept; returns out_valid one edge
  // after acceptance and the result two edges after, then returns at a negedge.
  task automatic run_single(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic v1, output logic v2, output logic [W-1:0] d,
                            output logic o, output logic [W-1:0] ud, output logic uo);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v1 = out_valid;
    @(posedge clk); #1;
    v2 = out_valid; d = out_data; o = out_ovf; ud = u_out_data; uo = u_out_ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (acc_value !== '0) begin miscompares++; $display("FAIL reset_acc got %h want 0", acc_value); end
    vectors++; if (u_acc_value !== '0) begin miscompares++; $display("FAIL reset_acc_u got %h want 0", u_acc_value); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (u_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_u got %b want 1", u_in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_basic_ops();
    logic [2:0]   ops [5];
    logic [W-1:0] as [5], bs [5], ed [5];
    logic v1, v2, o, uo;
    logic [W-1:0] d, ud;
    ops = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
    as  = '{32'd5, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bs  = '{32'd7, 32'd10, 32'd6, 32'd2, 32'd2};
    ed  = '{32'd12, 32'hFFFFFFF9, 32'hFFFFFFE8, 32'hFFFFFFFF, 32'd2};
    for (int i = 0; i < 5; i++) begin
      run_single(ops[i], as[i], bs[i], v1, v2, d, o, ud, uo);
      vectors++; if (v1 !== 1'b0) begin miscompares++; $display("FAIL basic%0d_early_valid got %b want 0", i, v1); end
      vectors++; if (v2 !== 1'b1) begin miscompares++; $display("FAIL basic%0d_valid got %b want 1", i, v2); end
      vectors++; if (d !== ed[i]) begin miscompares++; $display("FAIL basic%0d_data got %h want %h", i, d, ed[i]); end
      vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL basic%0d_ovf got %b want 0", i, o); end
    end
  endtask

  task automatic test_overflow();
    logic [2:0]   ops [7];
    logic [W-1:0] as [7], bs [7], ed [7], eud [7];
    logic         eo [7], euo [7];
    logic v1, v2, o, uo;
    logic [W-1:0] d, ud;
    ops = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd7, 3'd1, 3'd5};
    as  = '{32'h7FFFFFFF, 32'h10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd3, 32'hFFFFFFFF};
    bs  = '{32'd1, 32'h10000, 32'd1, 32'hFFFFFFFF, 32'd8, 32'd10, 32'd2};
    ed  = '{32'h80000000, 32'd0, 32'd0, 32'd1, 32'd15, 32'hFFFFFFF9, 32'hFFFFFFFF};
    eud = '{32'h80000000, 32'd0, 32'd0, 32'd1, 32'd15, 32'hFFFFFFF9, 32'd2};
    eo  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    euo = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_single(ops[i], as[i], bs[i], v1, v2, d, o, ud, uo);
      vectors++; if (d !== ed[i]) begin miscompares++; $display("FAIL ovf%0d_data got %h want %h", i, d, ed[i]); end
      vectors++; if (o !== eo[i]) begin miscompares++; $display("FAIL ovf%0d_flag got %b want %b", i, o, eo[i]); end
      vectors++; if (ud !== eud[i]) begin miscompares++; $display("FAIL ovf%0d_udata got %h want %h", i, ud, eud[i]); end
      vectors++; if (uo !== euo[i]) begin miscompares++; $display("FAIL ovf%0d_uflag got %b want %b", i, uo, euo[i]); end
    end
  endtask

  task automatic test_mac_chain();
    logic [W-1:0] exp_r [3];
    logic v1, v2, o, uo;
    logic [W-1:0] d, ud;
    exp_r = '{32'd6, 32'd26, 32'd25};
    in_valid = 1'b1; in_op = 3'd3; in_a = 32'd2; in_b = 32'd3;
    @(posedge clk); @(negedge clk);
    in_a = 32'd4; in_b = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_data !== exp_r[i]) begin
        miscompares++; $display("FAIL mac%0d_data got v=%b %h want v=1 %h", i, out_valid, out_data, exp_r[i]); end
      vectors++; if (acc_value !== exp_r[i]) begin miscompares++; $display("FAIL mac%0d_acc got %h want %h", i, acc_value, exp_r[i]); end
      vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL mac%0d_ovf got %b want 0", i, out_ovf); end
      if (i == 0) begin in_a = 32'd1; in_b = 32'hFFFFFFFF; end
      else in_valid = 1'b0;
    end
    run_single(3'd4, 32'd0, 32'd0, v1, v2, d, o, ud, uo);
    vectors++; if (d !== 32'd25) begin miscompares++; $display("FAIL clr_data got %h want 00000019", d); end
    vectors++; if (acc_value !== '0) begin miscompares++; $display("FAIL clr_acc got %h want 0", acc_value); end
    run_single(3'd3, 32'd3, 32'd3, v1, v2, d, o, ud, uo);
    vectors++; if (d !== 32'd9) begin miscompares++; $display("FAIL mac_after_clr got %h want 9", d); end
    vectors++; if (acc_value !== 32'd9) begin miscompares++; $display("FAIL mac_after_clr_acc got %h want 9", acc_value); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q [$];
    logic [W-1:0] hold_data, exp_d;
    logic hold_prev, need_new;
    int n, popped, cyc;
    localparam int TARGET = 1002;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n = 0; hold_prev = 1'b0; hold_data = '0;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0;
    for (int c = 0; c < 6; c++) begin
      in_a = 100 + n; in_b = 32'd1;
      #1;
      if (hold_prev) begin
        vectors++; if (out_valid !== 1'b1 || out_data !== hold_data) begin
          miscompares++; $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, out_data, hold_data); end
      end
      hold_prev = out_valid && !out_ready; hold_data = out_data;
      if (in_valid && in_ready) begin q.push_back(in_a + in_b); n++; end
      @(negedge clk);
    end
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL stall_accepts got %0d want 2", n); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    vectors++; if (out_data !== 32'd101) begin miscompares++; $display("FAIL stall_data got %h want 00000065", out_data); end
    popped = 0; cyc = 0; need_new = 1'b1;
    while (popped < TARGET && cyc < 6000) begin
      out_ready = (cyc == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = (n < TARGET);
      if (need_new) begin in_a = $urandom; in_b = $urandom; need_new = 1'b0; end
      #1;
      if (cyc == 0) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      end
      if (hold_prev) begin
        vectors++; if (out_valid !== 1'b1 || out_data !== hold_data) begin
          miscompares++; $display("FAIL rand_hold got v=%b %h want v=1 %h", out_valid, out_data, hold_data); end
      end
      hold_prev = out_valid && !out_ready; hold_data = out_data;
      if (out_valid && out_ready) begin
        vectors++;
        if (q.size() == 0) begin miscompares++; $display("FAIL rand_extra got %h want none", out_data); end
        else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin miscompares++; $display("FAIL rand_data%0d got %h want %h", popped, out_data, exp_d); end
        end
        popped++;
      end
      if (in_valid && in_ready) begin q.push_back(in_a + in_b); n++; need_new = 1'b1; end
      cyc++;
      @(negedge clk);
    end
    vectors++; if (popped !== TARGET) begin miscompares++; $display("FAIL rand_count got %0d want %0d", popped, TARGET); end
    vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL rand_leftover got %0d want 0", q.size()); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_throughput();
    logic ev;
    logic [W-1:0] ed;
    out_ready = 1'b1; in_op = 3'd0;
    for (int c = 0; c < 104; c++) begin
      in_valid = (c < 100); in_a = c; in_b = 2 * c;
      #1;
      if (c < 100) begin
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL tput_in_ready%0d got %b want 1", c, in_ready); end
      end
      ev = (c >= 2) && (c < 102);
      ed = 3 * (c - 2);
      vectors++; if (out_valid !== ev) begin miscompares++; $display("FAIL tput_valid%0d got %b want %b", c, out_valid, ev); end
      if (ev) begin
        vectors++; if (out_data !== ed) begin miscompares++; $display("FAIL tput_data%0d got %h want %h", c, out_data, ed); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic v1, v2, o, uo;
    logic [W-1:0] d, ud;
    run_single(3'd4, 32'd0, 32'd0, v1, v2, d, o, ud, uo);
    vectors++; if (d !== 32'd9) begin miscompares++; $display("FAIL mid_clr got %h want 9", d); end
    run_single(3'd3, 32'd4, 32'd4, v1, v2, d, o, ud, uo);
    run_single(3'd3, 32'd1, 32'd1, v1, v2, d, o, ud, uo);
    vectors++; if (acc_value !== 32'd17) begin miscompares++; $display("FAIL mid_acc17 got %h want 00000011", acc_value); end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 32'd1; in_b = 32'd1;
    @(posedge clk); @(negedge clk);
    in_op = 3'd3; in_a = 32'd2; in_b = 32'd2;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_full got v=%b r=%b want v=1 r=0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    vectors++; if (acc_value !== '0) begin miscompares++; $display("FAIL mid_rst_acc got %h want 0", acc_value); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale%0d got %b want 0", c, out_valid); end
    end
    vectors++; if (acc_value !== '0) begin miscompares++; $display("FAIL mid_acc_after got %h want 0", acc_value); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_ops();
    test_overflow();
    test_mac_chain();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
